// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RV64I funct3 load/store widths, base byte-enable patterns and the
// alignment check used before any bus beat is issued.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LSU_B   = 3'b000;
  localparam logic [2:0] LSU_H   = 3'b001;
  localparam logic [2:0] LSU_W   = 3'b010;
  localparam logic [2:0] LSU_D   = 3'b011;
  localparam logic [2:0] LSU_BU  = 3'b100;
  localparam logic [2:0] LSU_HU  = 3'b101;
  localparam logic [2:0] LSU_WU  = 3'b110;
  localparam logic [2:0] LSU_ILL = 3'b111;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Misaligned or illegal width; such accesses never reach the bus.
  function automatic logic lsu_bad_access(input logic [2:0] funct3, input logic [2:0] addr_lo);
    case (funct3)
      LSU_H, LSU_HU: return addr_lo[0];
      LSU_W, LSU_WU: return addr_lo[1:0] != 2'b00;
      LSU_D:         return addr_lo != 3'b000;
      LSU_ILL:       return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction: picks the byte/halfword/word selected by the low
// address bits out of a 32-bit bus word and sign- or zero-extends it to 64
// bits according to funct3. Doubleword assembly is handled by the caller.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata32_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] data_o
);

  logic [31:0] shifted;

  assign shifted = rdata32_i >> {addr_i, 3'b000};

  // Extend the selected lane to 64 bits.
  always_comb begin
    case (funct3_i)
      LSU_B:   data_o = {{56{shifted[7]}}, shifted[7:0]};
      LSU_H:   data_o = {{48{shifted[15]}}, shifted[15:0]};
      LSU_W:   data_o = {{32{shifted[31]}}, shifted};
      LSU_BU:  data_o = {56'b0, shifted[7:0]};
      LSU_HU:  data_o = {48'b0, shifted[15:0]};
      default: data_o = {32'b0, shifted};
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the RV64I data-memory port and a 32-bit
// valid/ready memory bus. Each core access becomes one bus beat (two for
// doublewords, low word first). Stall holds the PC until the one-cycle DONE.
//
// Optional feature macro: LSU_TIMEOUT_EN -- per-beat wait counter that
// aborts a beat after TIMEOUT_CYCLES cycles without bus_ready.
//
// state | meaning
// IDLE  | no access in flight; a request is checked and launched here
// BEAT0 | first (or only) bus beat presented, waiting for bus_ready
// BEAT1 | high word of a doubleword presented, waiting for bus_ready
// DONE  | single cycle: result/access_err valid, stall released
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_read_en,
  input  logic                  core_write_en,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [63:0]           core_write_data,
  input  logic [2:0]            core_width,
  output logic [63:0]           core_read_data,
  output logic                  stall,
  output logic                  access_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_byte_en,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_ready,
  input  logic [31:0]           bus_rdata
);

`ifdef LSU_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WAIT_W-1:0] wait_q;
`endif

  lsu_state_e            state_q;
  logic                  bus_req_q;
  logic                  bus_we_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic [3:0]            bus_be_q;
  logic [31:0]           bus_wdata_q;
  logic [63:0]           rd_data_q;
  logic                  err_q;
  logic [2:0]            width_q;
  logic [1:0]            off_q;
  logic [31:0]           wdata_hi_q;

  logic                  req;
  logic                  bad_access;
  logic [3:0]            be_d;
  logic [31:0]           wdata_d;
  logic [63:0]           load_ext;

  assign req        = core_read_en | core_write_en;
  assign bad_access = lsu_bad_access(core_width, core_addr[2:0]);

  // Reset gates stall so the core is released the instant reset asserts.
  assign stall          = rst & req & (state_q != ST_DONE);
  assign bus_req        = bus_req_q;
  assign bus_we         = bus_we_q;
  assign bus_addr       = bus_addr_q;
  assign bus_byte_en    = bus_be_q;
  assign bus_wdata      = bus_wdata_q;
  assign core_read_data = rd_data_q;
  assign access_err     = err_q;

  // Beat-0 lane strobes and replicated store data for the incoming request.
  always_comb begin
    case (core_width)
      LSU_B, LSU_BU: be_d = BE_BYTE << core_addr[1:0];
      LSU_H, LSU_HU: be_d = BE_HALF << core_addr[1:0];
      default:       be_d = BE_WORD;
    endcase
    case (core_width)
      LSU_B, LSU_BU: wdata_d = {4{core_write_data[7:0]}};
      LSU_H, LSU_HU: wdata_d = {2{core_write_data[15:0]}};
      default:       wdata_d = core_write_data[31:0];
    endcase
    if (!core_write_en) wdata_d = '0;
  end

  lsu_load_align u_load_align (
    .rdata32_i (bus_rdata),
    .addr_i    (off_q),
    .funct3_i  (width_q),
    .data_o    (load_ext)
  );

  // Access sequencer with registered bus and result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
      width_q     <= '0;
      off_q       <= '0;
      wdata_hi_q  <= '0;
`ifdef LSU_TIMEOUT_EN
      wait_q      <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            rd_data_q  <= '0;
            width_q    <= core_width;
            off_q      <= core_addr[1:0];
            wdata_hi_q <= core_write_data[63:32];
            if (bad_access) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              bus_req_q   <= 1'b1;
              bus_we_q    <= core_write_en;
              bus_addr_q  <= {core_addr[ADDR_WIDTH-1:2], 2'b00};
              bus_be_q    <= be_d;
              bus_wdata_q <= wdata_d;
              state_q     <= ST_BEAT0;
`ifdef LSU_TIMEOUT_EN
              wait_q      <= '0;
`endif
            end
          end
        end
        ST_BEAT0, ST_BEAT1: begin
          if (bus_ready) begin
`ifdef LSU_TIMEOUT_EN
            wait_q <= '0;
`endif
            if (state_q == ST_BEAT0 && width_q == LSU_D) begin
              if (!bus_we_q) rd_data_q[31:0] <= bus_rdata;
              bus_addr_q  <= bus_addr_q + ADDR_WIDTH'(4);
              bus_wdata_q <= bus_we_q ? wdata_hi_q : 32'h0;
              state_q     <= ST_BEAT1;
            end else begin
              if (!bus_we_q) begin
                if (width_q == LSU_D) rd_data_q[63:32] <= bus_rdata;
                else                  rd_data_q        <= load_ext;
              end
              bus_req_q   <= 1'b0;
              bus_we_q    <= 1'b0;
              bus_addr_q  <= '0;
              bus_be_q    <= '0;
              bus_wdata_q <= '0;
              state_q     <= ST_DONE;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            rd_data_q   <= '0;
            err_q       <= 1'b1;
            wait_q      <= '0;
            state_q     <= ST_DONE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end
        default: begin
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a task-driven core and bus responder
// with hand-computed expectations for loads, stores, alignment errors and
// asynchronous reset.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_read_en, core_write_en;
  logic [31:0] core_addr;
  logic [63:0] core_write_data;
  logic [2:0]  core_width;
  logic [63:0] core_read_data;
  logic        stall, access_err, bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  int          n_stall, n_beats;
  logic        done_seen, err_seen, req_seen;
  logic [63:0] rd_seen;
  logic [31:0] b_addr [2];
  logic [31:0] b_wd   [2];
  logic [3:0]  b_be   [2];
  logic        b_we   [2];

  load_store_unit dut (
    .clk             (clk),
    .rst             (rst),
    .core_read_en    (core_read_en),
    .core_write_en   (core_write_en),
    .core_addr       (core_addr),
    .core_write_data (core_write_data),
    .core_width      (core_width),
    .core_read_data  (core_read_data),
    .stall           (stall),
    .access_err      (access_err),
    .bus_req         (bus_req),
    .bus_we          (bus_we),
    .bus_addr        (bus_addr),
    .bus_byte_en     (bus_byte_en),
    .bus_wdata       (bus_wdata),
    .bus_ready       (bus_ready),
    .bus_rdata       (bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Runs one core access from a negedge; the bus answers each beat after dly wait cycles.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [2:0] w, input logic [63:0] wd, input int dly,
                           input logic [31:0] rlo, input logic [31:0] rhi, input int max_cyc);
    int wt;
    wt = 0;
    n_stall = 0; n_beats = 0; done_seen = 0; err_seen = 0; req_seen = 0; rd_seen = '0;
    core_read_en = rd; core_write_en = wr; core_addr = addr; core_width = w; core_write_data = wd;
    for (int cyc = 0; cyc < max_cyc && !done_seen; cyc++) begin
      #1;
      if (bus_req) req_seen = 1;
      if (stall) n_stall++;
      else begin
        done_seen = 1; err_seen = access_err; rd_seen = core_read_data;
      end
      bus_ready = 0;
      if (bus_req) begin
        if (wt == dly) begin
          bus_ready = 1;
          bus_rdata = (n_beats == 0) ? rlo : rhi;
          if (n_beats < 2) begin
            b_addr[n_beats] = bus_addr; b_wd[n_beats] = bus_wdata;
            b_be[n_beats] = bus_byte_en; b_we[n_beats] = bus_we;
          end
          n_beats++; wt = 0;
        end else wt++;
      end
      @(negedge clk);
    end
    core_read_en = 0; core_write_en = 0; bus_ready = 0;
  endtask

  task automatic test_reset();
    rst = 0; core_read_en = 1; core_write_en = 0; core_addr = 32'h104; core_width = LSU_W;
    core_write_data = '0; bus_ready = 0; bus_rdata = '0;
    #3;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_bus_req got=%b exp=0", bus_req); end
    total++; if ({bus_we, bus_addr, bus_byte_en, bus_wdata} !== '0) begin bad++;
      $display("FAIL rst_bus_fields got we=%b addr=%h be=%b wd=%h exp=all zero", bus_we, bus_addr, bus_byte_en, bus_wdata); end
    total++; if (core_read_data !== 64'h0 || access_err !== 1'b0) begin bad++;
      $display("FAIL rst_core_out got rd=%h err=%b exp=0/0", core_read_data, access_err); end
    core_read_en = 0;
    @(negedge clk); @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  w;
    logic [31:0] a;
    logic [31:0] rd;
    logic [63:0] exp;
    logic [3:0]  be;
  } ld_vec_t;

  task automatic test_loads();
    ld_vec_t lv[7];
    lv[0] = '{LSU_B,  32'h103, 32'h80FF_1234, 64'hFFFF_FFFF_FFFF_FF80, 4'b1000};
    lv[1] = '{LSU_HU, 32'h202, 32'hBEEF_0000, 64'h0000_0000_0000_BEEF, 4'b1100};
    lv[2] = '{LSU_BU, 32'h101, 32'h0000_A500, 64'h0000_0000_0000_00A5, 4'b0010};
    lv[3] = '{LSU_H,  32'h200, 32'h0000_8001, 64'hFFFF_FFFF_FFFF_8001, 4'b0011};
    lv[4] = '{LSU_W,  32'h008, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 4'b1111};
    lv[5] = '{LSU_WU, 32'h00C, 32'h8000_0000, 64'h0000_0000_8000_0000, 4'b1111};
    lv[6] = '{LSU_B,  32'h102, 32'h007F_0000, 64'h0000_0000_0000_007F, 4'b0100};
    for (int i = 0; i < 7; i++) begin
      do_access(1, 0, lv[i].a, lv[i].w, 64'h0, 0, lv[i].rd, 32'h0, 20);
      total++; if (done_seen !== 1'b1) begin bad++; $display("FAIL load%0d_done got=%b exp=1", i, done_seen); end
      total++; if (rd_seen !== lv[i].exp) begin bad++; $display("FAIL load%0d_data got=%h exp=%h", i, rd_seen, lv[i].exp); end
      total++; if (b_addr[0] !== {lv[i].a[31:2], 2'b00} || b_be[0] !== lv[i].be || b_we[0] !== 1'b0) begin bad++;
        $display("FAIL load%0d_beat got addr=%h be=%b we=%b exp addr=%h be=%b we=0", i, b_addr[0], b_be[0], b_we[0],
                 {lv[i].a[31:2], 2'b00}, lv[i].be); end
      total++; if (n_stall !== 2 || n_beats !== 1) begin bad++;
        $display("FAIL load%0d_timing got stall=%0d beats=%0d exp stall=2 beats=1", i, n_stall, n_beats); end
    end
  endtask

  task automatic test_ld();
    do_access(1, 0, 32'h80, LSU_D, 64'h0, 0, 32'hDEAD_BEEF, 32'h0123_4567, 20);
    total++; if (rd_seen !== 64'h0123_4567_DEAD_BEEF) begin bad++; $display("FAIL ld_data got=%h exp=0123_4567_DEAD_BEEF", rd_seen); end
    total++; if (n_stall !== 3 || n_beats !== 2) begin bad++;
      $display("FAIL ld_timing got stall=%0d beats=%0d exp stall=3 beats=2", n_stall, n_beats); end
    total++; if (b_addr[0] !== 32'h80 || b_addr[1] !== 32'h84 || b_be[1] !== 4'hF) begin bad++;
      $display("FAIL ld_beats got a0=%h a1=%h be1=%b exp 80/84/1111", b_addr[0], b_addr[1], b_be[1]); end
  endtask

  task automatic test_sd();
    do_access(0, 1, 32'h40, LSU_D, 64'h1122_3344_5566_7788, 2, 32'h0, 32'h0, 30);
    total++; if (b_addr[0] !== 32'h40 || b_wd[0] !== 32'h5566_7788 || b_be[0] !== 4'hF || b_we[0] !== 1'b1) begin bad++;
      $display("FAIL sd_beat0 got addr=%h wd=%h be=%b we=%b exp 40/55667788/1111/1", b_addr[0], b_wd[0], b_be[0], b_we[0]); end
    total++; if (b_addr[1] !== 32'h44 || b_wd[1] !== 32'h1122_3344 || b_be[1] !== 4'hF || b_we[1] !== 1'b1) begin bad++;
      $display("FAIL sd_beat1 got addr=%h wd=%h be=%b we=%b exp 44/11223344/1111/1", b_addr[1], b_wd[1], b_be[1], b_we[1]); end
    total++; if (n_stall !== 7 || err_seen !== 1'b0 || done_seen !== 1'b1) begin bad++;
      $display("FAIL sd_timing got stall=%0d err=%b done=%b exp 7/0/1", n_stall, err_seen, done_seen); end
  endtask

  task automatic test_sb_sh_sw();
    do_access(0, 1, 32'h11, LSU_B, 64'h1234_5678_9ABC_DEAB, 0, 32'h0, 32'h0, 20);
    total++; if (b_addr[0] !== 32'h10 || b_be[0] !== 4'b0010 || b_wd[0] !== 32'hABAB_ABAB || b_we[0] !== 1'b1) begin bad++;
      $display("FAIL sb_beat got addr=%h be=%b wd=%h we=%b exp 10/0010/ABABABAB/1", b_addr[0], b_be[0], b_wd[0], b_we[0]); end
    do_access(0, 1, 32'h22, LSU_H, 64'hFFFF_0000_AAAA_1234, 0, 32'h0, 32'h0, 20);
    total++; if (b_addr[0] !== 32'h20 || b_be[0] !== 4'b1100 || b_wd[0] !== 32'h1234_1234) begin bad++;
      $display("FAIL sh_beat got addr=%h be=%b wd=%h exp 20/1100/12341234", b_addr[0], b_be[0], b_wd[0]); end
    do_access(0, 1, 32'h34, LSU_W, 64'h0000_0001_CAFE_F00D, 1, 32'h0, 32'h0, 20);
    total++; if (b_addr[0] !== 32'h34 || b_be[0] !== 4'hF || b_wd[0] !== 32'hCAFE_F00D || n_stall !== 3) begin bad++;
      $display("FAIL sw_beat got addr=%h be=%b wd=%h stall=%0d exp 34/1111/CAFEF00D/3", b_addr[0], b_be[0], b_wd[0], n_stall); end
  endtask

  task automatic test_misaligned();
    do_access(1, 0, 32'h06, LSU_W, 64'h0, 0, 32'hFFFF_FFFF, 32'h0, 20);
    total++; if (err_seen !== 1'b1 || req_seen !== 1'b0 || rd_seen !== 64'h0 || n_stall !== 1) begin bad++;
      $display("FAIL lw_misaligned got err=%b req=%b rd=%h stall=%0d exp 1/0/0/1", err_seen, req_seen, rd_seen, n_stall); end
    #1;
    total++; if (access_err !== 1'b0) begin bad++; $display("FAIL err_pulse got=%b exp=0", access_err); end
    @(negedge clk);
    do_access(1, 0, 32'h100, LSU_ILL, 64'h0, 0, 32'hFFFF_FFFF, 32'h0, 20);
    total++; if (err_seen !== 1'b1 || req_seen !== 1'b0 || rd_seen !== 64'h0) begin bad++;
      $display("FAIL width111 got err=%b req=%b rd=%h exp 1/0/0", err_seen, req_seen, rd_seen); end
    do_access(0, 1, 32'h44, LSU_D, 64'h1, 0, 32'h0, 32'h0, 20);
    total++; if (err_seen !== 1'b1 || req_seen !== 1'b0) begin bad++;
      $display("FAIL sd_misaligned got err=%b req=%b exp 1/0", err_seen, req_seen); end
    do_access(1, 0, 32'h201, LSU_H, 64'h0, 0, 32'h0, 32'h0, 20);
    total++; if (err_seen !== 1'b1 || req_seen !== 1'b0) begin bad++;
      $display("FAIL lh_misaligned got err=%b req=%b exp 1/0", err_seen, req_seen); end
  endtask

  task automatic test_write_wins();
    do_access(1, 1, 32'h30, LSU_W, 64'h0000_0000_1357_9BDF, 0, 32'h0, 32'h0, 20);
    total++; if (b_we[0] !== 1'b1 || b_wd[0] !== 32'h1357_9BDF || rd_seen !== 64'h0) begin bad++;
      $display("FAIL write_wins got we=%b wd=%h rd=%h exp 1/13579BDF/0", b_we[0], b_wd[0], rd_seen); end
  endtask

  task automatic test_back_to_back();
    do_access(1, 0, 32'h50, LSU_W, 64'h0, 0, 32'h7654_3210, 32'h0, 20);
    total++; if (rd_seen !== 64'h0000_0000_7654_3210) begin bad++; $display("FAIL b2b_load got=%h exp=76543210", rd_seen); end
    do_access(0, 1, 32'h54, LSU_W, 64'h0000_0000_0BAD_CAFE, 0, 32'h0, 32'h0, 20);
    total++; if (b_addr[0] !== 32'h54 || b_wd[0] !== 32'h0BAD_CAFE || n_stall !== 2 || n_beats !== 1) begin bad++;
      $display("FAIL b2b_store got addr=%h wd=%h stall=%0d beats=%0d exp 54/0BADCAFE/2/1", b_addr[0], b_wd[0], n_stall, n_beats); end
  endtask

  task automatic test_reset_mid_ld();
    core_read_en = 1; core_write_en = 0; core_addr = 32'h40; core_width = LSU_D; bus_ready = 0;
    @(negedge clk);
    #1 bus_ready = 1; bus_rdata = 32'h1111_1111;
    @(negedge clk);
    #1 bus_ready = 0;
    total++; if (bus_req !== 1'b1 || bus_addr !== 32'h44) begin bad++;
      $display("FAIL mid_ld_beat1 got req=%b addr=%h exp 1/44", bus_req, bus_addr); end
    #2 rst = 0;
    #1;
    total++; if (bus_req !== 1'b0 || stall !== 1'b0) begin bad++;
      $display("FAIL mid_ld_reset got req=%b stall=%b exp 0/0", bus_req, stall); end
    core_read_en = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    total++; if (bus_req !== 1'b0 || stall !== 1'b0 || bus_addr !== 32'h0) begin bad++;
      $display("FAIL post_reset_idle got req=%b stall=%b addr=%h exp 0/0/0", bus_req, stall, bus_addr); end
    @(negedge clk);
    do_access(1, 0, 32'h61, LSU_BU, 64'h0, 0, 32'h0000_C300, 32'h0, 20);
    total++; if (rd_seen !== 64'hC3 || n_stall !== 2) begin bad++;
      $display("FAIL post_reset_load got rd=%h stall=%0d exp C3/2", rd_seen, n_stall); end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    do_access(1, 0, 32'h0, LSU_W, 64'h0, 100000, 32'h0, 32'h0, 400);
    total++; if (done_seen !== 1'b1 || err_seen !== 1'b1 || rd_seen !== 64'h0 || n_stall !== 256) begin bad++;
      $display("FAIL timeout got done=%b err=%b rd=%h stall=%0d exp 1/1/0/256", done_seen, err_seen, rd_seen, n_stall); end
  endtask
`endif

  initial begin
    test_reset();
    test_loads();
    test_ld();
    test_sd();
    test_sb_sh_sw();
    test_misaligned();
    test_write_wins();
    test_back_to_back();
    test_reset_mid_ld();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the RV64I single-cycle datapath's data-memory port and a 32-bit word-addressed memory bus with a valid/ready handshake.
- Converts one core load/store (B/H/W/D, funct3 encoded) into one or two bus beats. Doublewords take two beats: low word first, then high word.
- Performs byte-lane steering, load sign/zero extension and alignment checks.
- Asserts stall to freeze the PC until the access completes.

Parameters:
ADDR_WIDTH, 32, byte address width on core and bus side
TIMEOUT_CYCLES, 255, bus wait-cycle limit per beat (only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
core_read_en  in  1  load request, held stable by core while stall=1
core_write_en  in  1  store request, held stable by core while stall=1
core_addr  in  ADDR_WIDTH  byte address
core_write_data  in  64  store data, right-justified
core_width  in  3  funct3 (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal)
core_read_data  out  64  extended load result, valid in DONE
stall  out  1  core must not advance
access_err  out  1  misaligned/illegal access, pulses in DONE
bus_req  out  1  beat valid
bus_we  out  1  write beat
bus_addr  out  ADDR_WIDTH  word-aligned address, [1:0]=0
bus_byte_en  out  4  lane strobes
bus_wdata  out  32  lane-steered write data
bus_ready  in  1  beat accepted / read data valid
bus_rdata  in  32  read data

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; stall=0, bus_req=0, bus_we=0, bus_addr=0, bus_byte_en=0, bus_wdata=0, core_read_data=0, access_err=0. An in-flight beat is abandoned.
- FSM states: IDLE, BEAT0, BEAT1, DONE.
- Request and stall:
  - req = core_read_en | core_write_en; if both are set, the write wins.
  - stall = req & (state != DONE). Stall is combinational, so it rises in the same cycle the request appears.
- Alignment errors:
  - Misaligned: H with addr[0]=1; W/WU with addr[1:0]!=0; D with addr[2:0]!=0. Width 111 is illegal.
  - IDLE & req & error → DONE with access_err=1 and no bus activity. core_read_data=0; no store is performed.
- Normal flow:
  - IDLE & req & ok → BEAT0. The beat-0 bus fields and bus_req=1 are registered at this edge.
  - BEAT0: hold all bus outputs stable until bus_ready. Then go to BEAT1 if width=D (bus_addr+4, high word), else DONE.
  - BEAT1: hold until bus_ready, then DONE.
  - bus_req drops in the cycle after the final ready. Beats are never reissued.
- DONE: lasts exactly one cycle, with stall=0 and core_read_data valid. The core advances at the edge leaving DONE, then the unit returns to IDLE. A new request in IDLE begins on the next cycle, so there is no combinational re-trigger on the old instruction.
- Latency with bus_ready high immediately: 3 cycles for B/H/W, 4 for D.
- Stores:
  - SB: byte_en = 0001<<addr[1:0], data byte replicated on all lanes.
  - SH: byte_en = 0011<<addr[1:0], halfword replicated.
  - SW: byte_en = 1111.
  - SD: beat0 = wdata[31:0], beat1 = wdata[63:32], byte_en = 1111 on both beats.
- Loads:
  - B/H/W are extracted from the lane selected by addr[1:0], then sign- or zero-extended to 64 bits per funct3.
  - LD: beat0 rdata is captured into the low half, beat1 into the high half.
  - Load data is registered when bus_ready arrives.
- Request dropped mid-beat: this is illegal. The bus beat still completes and the unit goes to DONE normally.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: an 8-bit-or-wider wait counter clears at each beat start and increments while bus_req & ~bus_ready. On reaching TIMEOUT_CYCLES the beat is aborted: bus_req=0, state → DONE, access_err=1, core_read_data=0.
- Undefined: no counter; the unit waits on bus_ready indefinitely.

Decomposition:
- lsu_pkg holds:
  - the state enum (IDLE, BEAT0, BEAT1, DONE);
  - the funct3 width localparams (LSU_B … LSU_WU);
  - the byte-enable base constants.
- One combinational sub-module, lsu_load_align (inputs: rdata32, addr[1:0], funct3; output: 64-bit extended value), used for B/H/W loads. Store steering stays inline.

Test Plan:
- LB, addr=0x103, bus_rdata=0x80FF_1234 → bus_addr=0x100, byte_en=1000 implied read; core_read_data=0xFFFF_FFFF_FFFF_FF80; stall high for 2 cycles.
- LHU, addr=0x202, bus_rdata=0xBEEF_0000 → core_read_data=0x0000_0000_0000_BEEF.
- SD, addr=0x40, data=0x1122334455667788, bus_ready delayed 2 cycles per beat → beat0 addr 0x40 wdata 0x55667788 be=1111; beat1 addr 0x44 wdata 0x11223344; DONE after 7 cycles.
- SB, addr=0x11, data=0xAB → bus_addr=0x10, byte_en=0010, bus_wdata=0xABABABAB.
- LW, addr=0x06 → access_err=1 in DONE, bus_req never asserted; width=111 gives the same result.
- Reset asserted during BEAT1 of an LD → bus_req=0 and stall=0 immediately (asynchronous); after release the unit is in IDLE. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, bus_ready held low → access_err after 4 wait cycles.
